// File: rtl/galaxian_ram_arbiter_if.sv
// Bus bundle between the galaxian CPU, the hiscore engine and the shared work RAM.
// HISCORE_PAUSE_EN adds the hs_pause snapshot request.
interface galaxian_ram_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic          cpu_ce_in;
  logic          cpu_ce;
  logic [AW-1:0] cpu_addr;
  logic          cpu_we;
  logic [DW-1:0] cpu_din;
  logic [DW-1:0] cpu_dout;
  logic          hs_req;
  logic          hs_we;
  logic [AW-1:0] hs_addr;
  logic [DW-1:0] hs_din;
  logic          hs_ack;
  logic [DW-1:0] hs_dout;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
`ifdef HISCORE_PAUSE_EN
  logic          hs_pause;
`endif

  modport slave (
    input  cpu_ce_in, cpu_addr, cpu_we, cpu_din,
    input  hs_req, hs_we, hs_addr, hs_din,
    input  ram_dout,
`ifdef HISCORE_PAUSE_EN
    input  hs_pause,
`endif
    output cpu_ce, cpu_dout, hs_ack, hs_dout, ram_addr, ram_we, ram_din
  );

  modport master (
    output cpu_ce_in, cpu_addr, cpu_we, cpu_din,
    output hs_req, hs_we, hs_addr, hs_din,
    output ram_dout,
`ifdef HISCORE_PAUSE_EN
    output hs_pause,
`endif
    input  cpu_ce, cpu_dout, hs_ack, hs_dout, ram_addr, ram_we, ram_din
  );
endinterface

// File: rtl/galaxian_ram_arbiter.sv
// Shares the CPU work RAM port between the CPU (priority) and the hiscore engine.
// Optional HISCORE_PAUSE_EN: hs_pause freezes the CPU for a coherent RAM snapshot.
module galaxian_ram_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 15
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  galaxian_ram_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    HS_DONE = 1'b1
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [7:0]    wait_cnt_r;
  logic [7:0]    wait_cnt_nxt_s;
  logic          pause_s;
  logic          steal_s;
  logic          grant_s;
  logic          cpu_ce_s;
  logic          hs_ack_r;
  logic [DW-1:0] hs_dout_r;
  logic          cpu_rd_pend_r;
  logic [DW-1:0] cpu_dout_r;
  logic [AW-1:0] ram_addr_s;
  logic          ram_we_s;
  logic [DW-1:0] ram_din_s;

`ifdef HISCORE_PAUSE_EN
  assign pause_s = bus.hs_pause;
`else
  assign pause_s = 1'b0;
`endif

  // A starved request takes the CPU slot; the CPU sees its enable dropped and simply stalls.
  assign steal_s  = (wait_cnt_r == WAIT_LIMIT) & bus.hs_req & (state_r == IDLE);
  assign grant_s  = (state_r == IDLE) & bus.hs_req & (~bus.cpu_ce_in | steal_s | pause_s);
  assign cpu_ce_s = bus.cpu_ce_in & ~steal_s & ~pause_s;

  // RAM port multiplexer
  always_comb begin
    ram_addr_s = bus.cpu_addr;
    ram_we_s   = 1'b0;
    ram_din_s  = bus.cpu_din;
    if (cpu_ce_s) begin
      ram_addr_s = bus.cpu_addr;
      ram_we_s   = bus.cpu_we;
      ram_din_s  = bus.cpu_din;
    end else if (grant_s) begin
      ram_addr_s = bus.hs_addr;
      ram_we_s   = bus.hs_we;
      ram_din_s  = bus.hs_din;
    end else begin
      ram_addr_s = bus.cpu_addr;
      ram_we_s   = 1'b0;
      ram_din_s  = bus.cpu_din;
    end
  end

  // State and starvation counter registers
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      wait_cnt_r <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Next state and starvation count
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_nxt_s    = HS_DONE;
          wait_cnt_nxt_s = 8'd0;
        end else if (!bus.hs_req || pause_s) begin
          state_nxt_s    = IDLE;
          wait_cnt_nxt_s = 8'd0;
        end else if (wait_cnt_r < WAIT_LIMIT) begin
          state_nxt_s    = IDLE;
          wait_cnt_nxt_s = wait_cnt_r + 8'd1;
        end else begin
          state_nxt_s    = IDLE;
          wait_cnt_nxt_s = wait_cnt_r;
        end
      end
      HS_DONE: begin
        state_nxt_s    = IDLE;
        wait_cnt_nxt_s = wait_cnt_r;
      end
      default: begin
        state_nxt_s    = IDLE;
        wait_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // Hiscore completion: ack marks the HS_DONE cycle, read data is held after it
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hs_ack_r  <= 1'b0;
      hs_dout_r <= '0;
    end else begin
      hs_ack_r  <= grant_s;
      hs_dout_r <= (state_r == HS_DONE) ? bus.ram_dout : hs_dout_r;
    end
  end

  // CPU read return, one cycle after the RAM delivers the slot's data
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cpu_rd_pend_r <= 1'b0;
      cpu_dout_r    <= '0;
    end else begin
      cpu_rd_pend_r <= cpu_ce_s & ~bus.cpu_we;
      cpu_dout_r    <= cpu_rd_pend_r ? bus.ram_dout : cpu_dout_r;
    end
  end

  assign bus.cpu_ce   = cpu_ce_s;
  assign bus.cpu_dout = cpu_dout_r;
  assign bus.hs_ack   = hs_ack_r;
  // The RAM output is only valid during HS_DONE, so it bypasses the holding register then.
  assign bus.hs_dout  = hs_ack_r ? bus.ram_dout : hs_dout_r;
  assign bus.ram_addr = ram_addr_s;
  assign bus.ram_we   = ram_we_s & ~reset;
  assign bus.ram_din  = ram_din_s;

endmodule

// File: tb/tb_galaxian_ram_arbiter.sv
// Randomized self-checking bench for galaxian_ram_arbiter with a behavioural RAM and
// a transaction-level reference model (shadow memory, wait counter, delivery queues).
module tb_galaxian_ram_arbiter;
  localparam int AW       = 10;
  localparam int DW       = 8;
  localparam int MAX_WAIT = 15;

  logic clk_sys  = 1'b0;
  logic reset    = 1'b1;
  logic ram_init = 1'b1;

  always #5 clk_sys = ~clk_sys;

  galaxian_ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  galaxian_ram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  logic [7:0] ram_mem [0:1023];
  logic [7:0] ref_mem [0:1023];

  function automatic logic [7:0] init_val(input int i);
    if (i == 10'h0A5) return 8'h3C;
    else return 8'((i * 7 + 3) ^ (i >> 2));
  endfunction

  // Synchronous RAM, old data on read-during-write
  always @(posedge clk_sys) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] <= init_val(i);
      bus.ram_dout <= 8'h00;
    end else begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
      bus.ram_dout <= ram_mem[bus.ram_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model state
  bit         m_ack_due = 1'b0;
  int         m_waited  = 0;
  logic [7:0] m_ack_data = 8'h00;
  logic [7:0] m_hs_dout  = 8'h00;
  bit         m_rd_due   = 1'b0;
  logic [7:0] m_rd_data  = 8'h00;
  logic [7:0] m_cpu_dout = 8'h00;

  int         cyc     = 0;
  int         ce_mode = 0;
  logic       obs_cpu_ce, obs_ack;
  logic [9:0] obs_ram_addr;
  logic [7:0] obs_hs_dout;

  // One clock cycle: drive CPU side, predict, check, advance the model.
  task automatic tick();
    bit ce_in, pause, ack_now, stolen, serve, e_ce, e_we;
    logic [9:0] e_addr;
    logic [7:0] e_din;
    case (ce_mode)
      0:       ce_in = 1'b0;
      1:       ce_in = (cyc % 4 == 0);
      2:       ce_in = 1'b1;
      4:       ce_in = 1'b1;
      default: ce_in = ($urandom_range(0, 9) < 8);
    endcase
    bus.cpu_ce_in = ce_in;
    if (ce_mode == 4) begin
      bus.cpu_addr = 10'h0A5;
      bus.cpu_we   = 1'b0;
    end else begin
      bus.cpu_addr = 10'($urandom);
      bus.cpu_we   = ($urandom_range(0, 3) == 0);
    end
    bus.cpu_din = 8'($urandom);
`ifdef HISCORE_PAUSE_EN
    pause = bus.hs_pause;
`else
    pause = 1'b0;
`endif
    if (reset) begin
      m_ack_due = 1'b0; m_waited = 0; m_rd_due = 1'b0;
      m_cpu_dout = 8'h00; m_hs_dout = 8'h00;
    end
    ack_now = m_ack_due;
    stolen  = !ack_now && bus.hs_req && (m_waited >= MAX_WAIT);
    serve   = !ack_now && bus.hs_req && (!ce_in || stolen || pause);
    e_ce    = ce_in && !stolen && !pause;
    if (e_ce) begin
      e_addr = bus.cpu_addr; e_we = bus.cpu_we; e_din = bus.cpu_din;
    end else if (serve) begin
      e_addr = bus.hs_addr; e_we = bus.hs_we; e_din = bus.hs_din;
    end else begin
      e_addr = bus.cpu_addr; e_we = 1'b0; e_din = bus.cpu_din;
    end
    if (reset) e_we = 1'b0;
    #3;
    obs_cpu_ce   = bus.cpu_ce;
    obs_ack      = bus.hs_ack;
    obs_ram_addr = bus.ram_addr;
    obs_hs_dout  = bus.hs_dout;
    chk("cpu_ce", bus.cpu_ce, e_ce);
    chk("ram_we", bus.ram_we, e_we);
    if (!reset) chk("ram_addr", bus.ram_addr, e_addr);
    if (e_we) chk("ram_din", bus.ram_din, e_din);
    chk("hs_ack", bus.hs_ack, ack_now);
    chk("hs_dout", bus.hs_dout, ack_now ? m_ack_data : m_hs_dout);
    chk("cpu_dout", bus.cpu_dout, m_cpu_dout);
    if (!reset) begin
      if (ack_now) m_hs_dout = m_ack_data;
      if (m_rd_due) m_cpu_dout = m_rd_data;
      m_rd_due  = e_ce && !bus.cpu_we;
      m_rd_data = ref_mem[bus.cpu_addr];
      if (serve) m_ack_data = ref_mem[bus.hs_addr];
      if (e_we) ref_mem[e_addr] = e_din;
      if (!ack_now) begin
        if (!bus.hs_req || serve || pause) m_waited = 0;
        else if (m_waited < MAX_WAIT) m_waited = m_waited + 1;
      end
      m_ack_due = serve;
    end
    cyc++;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic hs_access(input bit we, input logic [9:0] addr, input logic [7:0] din,
                           output logic [7:0] dout, output int n);
    bus.hs_req = 1'b1; bus.hs_we = we; bus.hs_addr = addr; bus.hs_din = din;
    n = 0; dout = 8'h00;
    forever begin
      tick();
      n++;
      if (obs_ack) begin
        dout = obs_hs_dout;
        break;
      end
      if (n >= 64) begin
        chk("hs_timeout", obs_ack, 1'b1);
        break;
      end
    end
    bus.hs_req = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int n, lo_cnt, lo_first, ack1, ack2, acks;
    bus.hs_req = 1'b0; bus.hs_we = 1'b0; bus.hs_addr = '0; bus.hs_din = '0;
    bus.cpu_ce_in = 1'b0; bus.cpu_addr = '0; bus.cpu_we = 1'b0; bus.cpu_din = '0;
`ifdef HISCORE_PAUSE_EN
    bus.hs_pause = 1'b0;
`endif
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);

    // reset: cpu_ce follows cpu_ce_in, no RAM write, outputs cleared
    @(posedge clk_sys); #1;
    ce_mode = 2; tick();
    ce_mode = 0; tick();
    ram_init = 1'b0; tick();
    reset = 1'b0;

    // CPU read of 0x0A5
    ce_mode = 4; tick();
    chk("t1_addr", obs_ram_addr, 10'h0A5);
    chk("t1_ack", obs_ack, 1'b0);
    ce_mode = 0; tick();
    chk("t1_cpu_dout", bus.cpu_dout, 8'h3C);

    // 1-in-4 CPU slots; request starts on a CPU slot so it is deferred one cycle
    ce_mode = 1;
    while (cyc % 4 != 0) tick();
    hs_access(1'b1, 10'h3FF, 8'h5A, d, n);
    chk("t2_wr_lat", n, 3);
    while (cyc % 4 != 0) tick();
    hs_access(1'b0, 10'h3FF, 8'h00, d, n);
    chk("t2_rd_lat", n, 3);
    chk("t2_rd_data", d, 8'h5A);

    // CPU hogs every slot: steals at cycle 16 and every MAX_WAIT+2 after
    ce_mode = 2;
    bus.hs_req = 1'b1; bus.hs_we = 1'b0; bus.hs_addr = 10'h010;
    lo_cnt = 0; lo_first = -1; ack1 = -1; ack2 = -1;
    for (int k = 1; k <= 36; k++) begin
      tick();
      if (!obs_cpu_ce) begin
        lo_cnt++;
        if (lo_first < 0) lo_first = k;
      end
      if (obs_ack) begin
        if (ack1 < 0) ack1 = k;
        else if (ack2 < 0) ack2 = k;
      end
    end
    bus.hs_req = 1'b0;
    chk("t3_steal_cyc", lo_first, 16);
    chk("t3_steal_cnt", lo_cnt, 2);
    chk("t3_ack1", ack1, 17);
    chk("t3_ack2", ack2, 34);
    tick();

    // reset during HS_DONE kills the ack; held request is served afresh
    ce_mode = 0;
    bus.hs_req = 1'b1; bus.hs_we = 1'b0; bus.hs_addr = 10'h020;
    tick();
    reset = 1'b1; tick();
    chk("t5_ack_in_rst", obs_ack, 1'b0);
    reset = 1'b0; tick();
    chk("t5_no_ack", obs_ack, 1'b0);
    tick();
    chk("t5_ack", obs_ack, 1'b1);
    chk("t5_data", obs_hs_dout, init_val(10'h020));
    bus.hs_req = 1'b0; tick();

`ifdef HISCORE_PAUSE_EN
    bus.hs_pause = 1'b1; ce_mode = 2;
    bus.hs_req = 1'b1; bus.hs_we = 1'b0; bus.hs_addr = 10'h100;
    acks = 0; lo_cnt = 0; ack1 = -1; ack2 = -1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (!obs_cpu_ce) lo_cnt++;
      if (obs_ack) begin
        acks++;
        if (ack1 < 0) ack1 = k;
        else if (ack2 < 0) ack2 = k;
        bus.hs_addr = bus.hs_addr + 10'd1;
      end
    end
    bus.hs_req = 1'b0; bus.hs_pause = 1'b0;
    chk("t6_acks", acks, 8);
    chk("t6_ce_low", lo_cnt, 16);
    chk("t6_spacing", ack2 - ack1, 2);
    tick();
`else
    acks = 0;
`endif

    // random traffic with abandoned requests and occasional resets
    for (int k = 0; k < 4000; k++) begin
      ce_mode = ((k / 500) % 2 == 1) ? 2 : 3;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 999) == 0) reset = 1'b1;
      if (!bus.hs_req) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.hs_req  = 1'b1;
          bus.hs_we   = ($urandom_range(0, 1) == 1);
          bus.hs_addr = 10'($urandom);
          bus.hs_din  = 8'($urandom);
        end
      end else if (obs_ack || $urandom_range(0, 49) == 0) begin
        bus.hs_req = 1'b0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
